// File: rtl/draw_seq_pkg.sv
// draw_seq_pkg: shared types and defaults for draw_pair_sequencer (optional abort via DRAW_SEQ_ABORT_EN).
package draw_seq_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef logic req_id_t;

    typedef struct packed {
        logic [ADDR_W_DEF-2:0] base;
        logic [ADDR_W_DEF-2:0] len;
        logic [DATA_W_DEF-1:0] data;
    } job_t;

endpackage

// File: rtl/draw_rr_arbiter.sv
// draw_rr_arbiter: two-way round-robin picker; on a tie the requester not granted last wins.
module draw_rr_arbiter
    import draw_seq_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       en,
    input  req_id_t    last,
    output logic [1:0] grant,
    output req_id_t    id
);

    assign id    = &valid ? ~last : valid[1];
    assign grant = (en && |valid) ? (id ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/draw_pair_sequencer.sv
// draw_pair_sequencer: arbitrates two job requesters onto a paired even/odd framebuffer write path.
// Defining DRAW_SEQ_ABORT_EN adds an abort input and an aborted pulse output.
module draw_pair_sequencer
    import draw_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-2:0] req0_base,
    input  logic [ADDR_W-2:0] req0_len,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-2:0] req1_base,
    input  logic [ADDR_W-2:0] req1_len,
    input  logic [DATA_W-1:0] req1_data,
`ifdef DRAW_SEQ_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              grant_id
);

    localparam int PW = ADDR_W - 1;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     rem_q, rem_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    req_id_t           grant_id_q, grant_id_d;
    req_id_t           last_q, last_d;
    logic              stop;

`ifdef DRAW_SEQ_ABORT_EN
    logic aborted_q, aborted_d;
    assign stop    = abort;
    assign aborted = aborted_q;
`else
    assign stop = 1'b0;
`endif

    logic [1:0]        grant;
    req_id_t           win_id;
    logic              hs;
    logic [PW-1:0]     sel_base, sel_len;
    logic [DATA_W-1:0] sel_data;

    draw_rr_arbiter u_arb (
        .valid ({req1_valid, req0_valid}),
        .en    (state_q == IDLE),
        .last  (last_q),
        .grant (grant),
        .id    (win_id)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign hs         = |grant;
    assign sel_base   = win_id ? req1_base : req0_base;
    assign sel_len    = win_id ? req1_len  : req0_len;
    assign sel_data   = win_id ? req1_data : req0_data;

    // Outputs are computed for the state being entered so they appear registered.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        grant_id_d = grant_id_q;
        last_d     = last_q;
`ifdef DRAW_SEQ_ABORT_EN
        aborted_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (hs) begin
                    grant_id_d = win_id;
                    last_d     = win_id;
                    busy_d     = 1'b1;
                    if (sel_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = RUN;
                        wr_en_d   = 1'b1;
                        addr_a_d  = {sel_base, 1'b0};
                        addr_b_d  = {sel_base, 1'b1};
                        wr_data_d = sel_data;
                        ptr_d     = sel_base + 1'b1;
                        rem_d     = sel_len - 1'b1;
                    end
                end
            end
            RUN: begin
                if (rem_q == '0 || stop) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
`ifdef DRAW_SEQ_ABORT_EN
                    aborted_d = stop;
`endif
                end else begin
                    wr_en_d  = 1'b1;
                    addr_a_d = {ptr_q, 1'b0};
                    addr_b_d = {ptr_q, 1'b1};
                    ptr_d    = ptr_q + 1'b1;
                    rem_d    = rem_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= ADDR_W'(1);
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            grant_id_q <= 1'b0;
            last_q     <= 1'b1;
`ifdef DRAW_SEQ_ABORT_EN
            aborted_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
`ifdef DRAW_SEQ_ABORT_EN
            aborted_q  <= aborted_d;
`endif
        end
    end

    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_draw_pair_sequencer.sv
// tb_draw_pair_sequencer: job-timeline model plus directed vectors for draw_pair_sequencer.
module tb_draw_pair_sequencer;
    import draw_seq_pkg::*;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [AW-2:0] req0_base = '0, req0_len = '0, req1_base = '0, req1_len = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wr_data;
    logic          wr_en, busy, done, grant_id;
`ifdef DRAW_SEQ_ABORT_EN
    logic abort = 1'b0;
    logic aborted;
    wire  abort_s = abort;
`else
    wire  abort_s = 1'b0;
`endif

    int   checks = 0;
    int   errors = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    draw_pair_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_base  (req0_base),
        .req0_len   (req0_len),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_base  (req1_base),
        .req1_len   (req1_len),
        .req1_data  (req1_data),
`ifdef DRAW_SEQ_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .grant_id   (grant_id)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Job timeline model: m_j counts cycles since the handshake; writes for j<len, done at j==len.
    logic        m_act = 1'b0, m_last = 1'b1, m_gid = 1'b0, m_abort = 1'b0;
    int          m_j = 0, m_len = 0;
    logic [12:0] m_base = '0, m_pair = '0;
    logic [7:0]  m_wdata = '0;
    wire         m_idle = !m_act || m_j > m_len;
    wire         m_win  = (req0_valid && req1_valid) ? !m_last : req1_valid;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_act <= 1'b0; m_last <= 1'b1; m_gid <= 1'b0; m_abort <= 1'b0;
            m_j <= 0; m_len <= 0; m_pair <= '0; m_wdata <= '0;
        end else if (m_idle && (req0_valid || req1_valid)) begin
            m_act   <= 1'b1;
            m_j     <= 0;
            m_gid   <= m_win;
            m_last  <= m_win;
            m_abort <= 1'b0;
            m_base  <= m_win ? req1_base : req0_base;
            m_len   <= 32'(m_win ? req1_len : req0_len);
            if ((m_win ? req1_len : req0_len) != 13'd0) begin
                m_pair  <= m_win ? req1_base : req0_base;
                m_wdata <= m_win ? req1_data : req0_data;
            end
        end else if (!m_idle) begin
            m_j <= m_j + 1;
            if (abort_s && m_j < m_len) begin
                m_len   <= m_j + 1;
                m_abort <= 1'b1;
            end else if (m_j + 1 < m_len) begin
                m_pair <= m_base + 13'(m_j + 1);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("wr_en",    32'(wr_en),      32'(m_act && m_j < m_len));
            chk("done",     32'(done),       32'(m_act && m_j == m_len));
            chk("busy",     32'(busy),       32'(m_act && m_j <= m_len));
            chk("addr_a",   32'(addr_a),     32'({m_pair, 1'b0}));
            chk("addr_b",   32'(addr_b),     32'({m_pair, 1'b1}));
            chk("wr_data",  32'(wr_data),    32'(m_wdata));
            chk("grant_id", 32'(grant_id),   32'(m_gid));
            chk("ready0",   32'(req0_ready), 32'(m_idle && req0_valid && !m_win));
            chk("ready1",   32'(req1_ready), 32'(m_idle && req1_valid && m_win));
`ifdef DRAW_SEQ_ABORT_EN
            chk("aborted",  32'(aborted),    32'(m_act && m_j == m_len && m_abort));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input req_id_t id, input job_t j);
        if (id) begin
            req1_base = j.base; req1_len = j.len; req1_data = j.data; req1_valid = 1'b1;
        end else begin
            req0_base = j.base; req0_len = j.len; req0_data = j.data; req0_valid = 1'b1;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300 && busy !== 1'b0; c++) tick();
        chk("idle_reached", 32'(busy), 0);
    endtask

    logic [AW-1:0] wrap_a [4];
    logic [3:0]    rr_seq;

    initial begin
        wrap_a = '{14'd16380, 14'd16382, 14'd0, 14'd2};
        rr_seq = 4'b1010;
        #3 reset = 1'b0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        chk("rst_addr_a", 32'(addr_a), 0);
        chk("rst_addr_b", 32'(addr_b), 1);
        chk("rst_gid",    32'(grant_id), 0);
        reset = 1'b1;
        tick();

        issue(1'b0, '{13'd2816, 13'd128, 8'h3C});
        chk("t1_first_a", 32'(addr_a), 5632);
        chk("t1_first_b", 32'(addr_b), 5633);
        chk("t1_first_we", 32'(wr_en), 1);
        repeat (127) tick();
        chk("t1_last_a", 32'(addr_a), 5886);
        chk("t1_last_b", 32'(addr_b), 5887);
        chk("t1_last_we", 32'(wr_en), 1);
        tick();
        chk("t1_done", 32'(done), 1);
        chk("t1_done_we", 32'(wr_en), 0);
        chk("t1_done_busy", 32'(busy), 1);
        tick();
        chk("t1_busy_drop", 32'(busy), 0);
        chk("t1_done_drop", 32'(done), 0);

        issue(1'b0, '{13'd5, 13'd0, 8'h11});
        chk("t3_done", 32'(done), 1);
        chk("t3_busy", 32'(busy), 1);
        chk("t3_we", 32'(wr_en), 0);
        tick();
        chk("t3_busy_drop", 32'(busy), 0);

        issue(1'b1, '{13'd8190, 13'd4, 8'h77});
        for (int k = 0; k < 4; k++) begin
            chk("t4_wrap_a", 32'(addr_a), 32'(wrap_a[k]));
            tick();
        end
        chk("t4_done", 32'(done), 1);
        wait_idle();

        issue(1'b0, '{13'd1000, 13'd50, 8'h99});
        repeat (9) tick();
        chk("t5_10th_a", 32'(addr_a), 2018);
        reset = 1'b0;
        #1;
        chk("t5_rst_we",   32'(wr_en), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_done", 32'(done), 0);
        chk("t5_rst_a",    32'(addr_a), 0);
        chk("t5_rst_b",    32'(addr_b), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) tick();
        chk("t5_no_done", 32'(done), 0);
        issue(1'b1, '{13'd10, 13'd3, 8'h42});
        chk("t5_new_a", 32'(addr_a), 20);
        chk("t5_new_gid", 32'(grant_id), 1);
        wait_idle();

        req0_base = 13'd100; req0_len = 13'd3; req0_data = 8'hAA;
        req1_base = 13'd200; req1_len = 13'd2; req1_data = 8'h55;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 20 && done !== 1'b1; c++) tick();
            chk("rr_done", 32'(done), 1);
            chk("rr_gid", 32'(grant_id), 32'(rr_seq[k]));
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

`ifdef DRAW_SEQ_ABORT_EN
        issue(1'b0, '{13'd300, 13'd100, 8'h5A});
        repeat (4) tick();
        chk("ab_5th_a", 32'(addr_a), 608);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_done", 32'(done), 1);
        chk("ab_aborted", 32'(aborted), 1);
        chk("ab_we", 32'(wr_en), 0);
        wait_idle();
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
